seg14_scan_decoder: RTL and testbench

- Receive-side counterpart of the 12-digit, 14-segment multiplexed display scanner.
- Watches the one-hot digit select `sel` and the segment bus `segm`, decodes each 14-segment glyph back to a 7-bit ASCII code, and assembles complete 12-character frames.
- Committed frames sit in a readable frame buffer; used as an on-chip loopback checker for display drivers and as a capture block for external scanned displays.

---
 rtl/seg14_pkg.sv | 44 ++++
 rtl/seg14_glyph_decode.sv | 17 +
 rtl/seg14_scan_decoder.sv | 126 ++++++++++++
 tb/tb_seg14_scan_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg14_pkg.sv
// Shared 14-segment glyph set, glyph->ASCII table and decoder FSM states.
// Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

  localparam logic [6:0] SEG14_BAD_CHAR = 7'h3F;

  typedef enum logic [1:0] {HUNT, FILL, COMMIT} state_e;

  localparam logic [13:0] GL_SPACE = 14'h0000;
  localparam logic [13:0] GL_A = 14'h3BC0, GL_B = 14'h3C52, GL_C = 14'h2700, GL_D = 14'h3C12;
  localparam logic [13:0] GL_E = 14'h2780, GL_F = 14'h2380, GL_G = 14'h2F40, GL_H = 14'h1BC0;
  localparam logic [13:0] GL_I = 14'h2412, GL_J = 14'h1E00, GL_K = 14'h038C, GL_L = 14'h0700;
  localparam logic [13:0] GL_M = 14'h1B28, GL_N = 14'h1B24, GL_O = 14'h3F00, GL_P = 14'h33C0;
  localparam logic [13:0] GL_Q = 14'h3F04, GL_R = 14'h33C4, GL_S = 14'h2DC0, GL_T = 14'h2012;
  localparam logic [13:0] GL_U = 14'h1F00, GL_V = 14'h0309, GL_W = 14'h1B05, GL_X = 14'h002D;
  localparam logic [13:0] GL_Y = 14'h002A, GL_Z = 14'h2409, GL_NTILDE = 14'h3B24;
  localparam logic [13:0] GL_0 = 14'h3F09, GL_1 = 14'h1808, GL_2 = 14'h36C0, GL_3 = 14'h3C40;
  localparam logic [13:0] GL_4 = 14'h19C0, GL_5 = 14'h2584, GL_6 = 14'h2FC0, GL_7 = 14'h3800;
  localparam logic [13:0] GL_8 = 14'h3FC0, GL_9 = 14'h3DC0;

  // Returns {known, ascii}; N-tilde has no 7-bit code and is reported as '~'.
  function automatic logic [7:0] seg14_to_ascii(input logic [13:0] g);
    logic [6:0] c;
    logic       k;
    c = SEG14_BAD_CHAR;
    k = 1'b1;
    case (g)
      GL_SPACE: c = 7'h20;
      GL_A: c = 7'h41;  GL_B: c = 7'h42;  GL_C: c = 7'h43;  GL_D: c = 7'h44;
      GL_E: c = 7'h45;  GL_F: c = 7'h46;  GL_G: c = 7'h47;  GL_H: c = 7'h48;
      GL_I: c = 7'h49;  GL_J: c = 7'h4A;  GL_K: c = 7'h4B;  GL_L: c = 7'h4C;
      GL_M: c = 7'h4D;  GL_N: c = 7'h4E;  GL_O: c = 7'h4F;  GL_P: c = 7'h50;
      GL_Q: c = 7'h51;  GL_R: c = 7'h52;  GL_S: c = 7'h53;  GL_T: c = 7'h54;
      GL_U: c = 7'h55;  GL_V: c = 7'h56;  GL_W: c = 7'h57;  GL_X: c = 7'h58;
      GL_Y: c = 7'h59;  GL_Z: c = 7'h5A;  GL_NTILDE: c = 7'h7E;
      GL_0: c = 7'h30;  GL_1: c = 7'h31;  GL_2: c = 7'h32;  GL_3: c = 7'h33;
      GL_4: c = 7'h34;  GL_5: c = 7'h35;  GL_6: c = 7'h36;  GL_7: c = 7'h37;
      GL_8: c = 7'h38;  GL_9: c = 7'h39;
      default: k = 1'b0;
    endcase
    return {k, c};
  endfunction

endpackage

// File: rtl/seg14_glyph_decode.sv
// Combinational 14-segment glyph -> ASCII decode with unknown-glyph flag.
module seg14_glyph_decode
  import seg14_pkg::*;
#(
  parameter logic [6:0] BAD_CHAR = SEG14_BAD_CHAR
) (
  input  logic [13:0] segm,
  output logic [6:0]  ascii,
  output logic        known
);

  logic [6:0] raw;

  assign {known, raw} = seg14_to_ascii(segm);
  assign ascii = known ? raw : BAD_CHAR;

endmodule

// File: rtl/seg14_scan_decoder.sv
// Recovers ASCII frames from a multiplexed 14-segment scan (sel one-hot + segm)
// and commits whole frames to a readable buffer.
module seg14_scan_decoder
  import seg14_pkg::*;
#(
  parameter int         NUM_DIGITS = 12,
  parameter int         IDX_W      = 4,
  parameter logic [6:0] BAD_CHAR   = SEG14_BAD_CHAR
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_DIGITS-1:0] sel,
  input  logic [13:0]           segm,
  input  logic [IDX_W-1:0]      rd_addr,
  output logic [6:0]            rd_char,
  output logic                  frame_valid,
  output logic                  frame_changed,
  output logic                  frame_glyph_err,
  output logic                  seq_err,
  output logic [7:0]            frame_count
);

  logic [NUM_DIGITS-1:0]       sel_q, sel_prev;
  logic [13:0]                 segm_q;
  state_e                      state, state_nx;
  logic [IDX_W-1:0]            exp_q, exp_nx, cur_exp, idx;
  logic [NUM_DIGITS-1:0][6:0]  fill, frame;
  logic                        err_q, err_nx;
  logic [6:0]                  ascii;
  logic                        known, onehot, evt, bad_sel, wr, commit, seq_nx;

  seg14_glyph_decode #(.BAD_CHAR(BAD_CHAR)) u_dec (
    .segm  (segm_q),
    .ascii (ascii),
    .known (known)
  );

  // A held sel is one event; a held bad sel likewise reports once.
  always_comb begin
    onehot  = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
    evt     = onehot && (sel_q != sel_prev);
    bad_sel = (sel_q != '0) && !onehot && (sel_q != sel_prev);
    idx     = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (sel_q[i]) idx = IDX_W'(i);
  end

  always_comb begin
    state_nx = state;
    exp_nx   = exp_q;
    wr       = 1'b0;
    seq_nx   = 1'b0;
    commit   = (state == COMMIT);
    cur_exp  = commit ? '0 : exp_q;
    if (bad_sel) begin
      seq_nx   = 1'b1;
      state_nx = HUNT;
    end else if (evt) begin
      if (state == HUNT) begin
        if (idx == '0) begin
          wr       = 1'b1;
          exp_nx   = IDX_W'(1);
          state_nx = FILL;
        end
      end else if (idx == cur_exp) begin
        wr = 1'b1;
        if (int'(idx) == NUM_DIGITS - 1) state_nx = COMMIT;
        else begin
          exp_nx   = idx + IDX_W'(1);
          state_nx = FILL;
        end
      end else if (idx == '0) begin
        seq_nx   = 1'b1;
        wr       = 1'b1;
        exp_nx   = IDX_W'(1);
        state_nx = FILL;
      end else begin
        seq_nx   = 1'b1;
        state_nx = HUNT;
      end
    end else if (commit) begin
      exp_nx   = '0;
      state_nx = FILL;
    end
    // Digit 0 always opens a fresh frame, so it also resets the error flag.
    err_nx = commit ? 1'b0 : err_q;
    if (wr) err_nx = ((idx == '0) ? 1'b0 : err_nx) | !known;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q           <= '0;
      sel_prev        <= '0;
      segm_q          <= '0;
      state           <= HUNT;
      exp_q           <= '0;
      err_q           <= 1'b0;
      fill            <= {NUM_DIGITS{7'h20}};
      frame           <= {NUM_DIGITS{7'h20}};
      rd_char         <= '0;
      frame_valid     <= 1'b0;
      frame_changed   <= 1'b0;
      frame_glyph_err <= 1'b0;
      seq_err         <= 1'b0;
      frame_count     <= '0;
    end else begin
      sel_q           <= sel;
      segm_q          <= segm;
      sel_prev        <= sel_q;
      state           <= state_nx;
      exp_q           <= exp_nx;
      err_q           <= err_nx;
      seq_err         <= seq_nx;
      frame_valid     <= commit;
      frame_changed   <= commit && (fill != frame);
      frame_glyph_err <= commit && err_q;
      if (wr) fill[idx] <= ascii;
      if (commit) begin
        frame       <= fill;
        frame_count <= frame_count + 8'd1;
      end
      rd_char <= (int'(rd_addr) < NUM_DIGITS) ? frame[rd_addr] : 7'h20;
    end
  end

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Random and directed scan streams checked against an event-level frame model.
module tb_seg14_scan_decoder;

  localparam int ND = 12;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [ND-1:0] sel = '0;
  logic [13:0]   segm = '0;
  logic [3:0]    rd_addr = '0;
  logic [6:0]    rd_char;
  logic          frame_valid, frame_changed, frame_glyph_err, seq_err;
  logic [7:0]    frame_count;

  seg14_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .segm(segm), .rd_addr(rd_addr),
    .rd_char(rd_char), .frame_valid(frame_valid), .frame_changed(frame_changed),
    .frame_glyph_err(frame_glyph_err), .seq_err(seq_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [13:0] glyph(byte c);
    case (c)
      "A": return 14'h3BC0;  "C": return 14'h2700;  "G": return 14'h2F40;
      "I": return 14'h2412;  "P": return 14'h33C0;  "R": return 14'h33C4;
      "T": return 14'h2012;  "Y": return 14'h002A;  default: return 14'h0000;
    endcase
  endfunction

  // Reference model: works on the driven stream, one digit event at a time.
  typedef struct { bit changed; bit err; } fexp_t;
  fexp_t         fq[$];
  fexp_t         fe;
  byte           last_frame[ND];
  byte           part[ND];
  bit            hunting = 1'b1, perr = 1'b0;
  int            nxt = 0, exp_count = 0, exp_seq = 0;
  logic [ND-1:0] prev_sel = '0;

  task automatic model_reset();
    hunting = 1'b1; perr = 1'b0; nxt = 0; exp_count = 0; prev_sel = '0;
    for (int i = 0; i < ND; i++) last_frame[i] = " ";
  endtask

  task automatic model_event(int idx, byte ch, bit bad);
    byte   v;
    fexp_t e;
    v = bad ? 8'h3F : ch;
    if (hunting) begin
      if (idx == 0) begin part[0] = v; perr = bad; nxt = 1; hunting = 1'b0; end
    end else if (idx == nxt) begin
      part[idx] = v; perr = perr | bad; nxt++;
      if (nxt == ND) begin
        e.changed = 1'b0;
        for (int i = 0; i < ND; i++) if (part[i] != last_frame[i]) e.changed = 1'b1;
        e.err = perr;
        fq.push_back(e);
        last_frame = part;
        exp_count++; nxt = 0; perr = 1'b0;
      end
    end else if (idx == 0) begin
      exp_seq++; part[0] = v; perr = bad; nxt = 1;
    end else begin
      exp_seq++; hunting = 1'b1;
    end
  endtask

  task automatic drive(logic [ND-1:0] s, byte ch, bit bad);
    @(posedge clk); #1;
    sel  = s;
    segm = bad ? 14'h1555 : glyph(ch);
    if (s != prev_sel && s != '0) begin
      if ($countones(s) == 1) begin
        for (int i = 0; i < ND; i++) if (s[i]) model_event(i, ch, bad);
      end else begin
        exp_seq++; hunting = 1'b1;
      end
    end
    prev_sel = s;
  endtask

  task automatic idle(int n);
    repeat (n) drive('0, " ", 1'b0);
  endtask

  task automatic send(string s, int hold, int bad_at);
    for (int i = 0; i < ND; i++)
      repeat (hold) drive(ND'(1) << i, s[i], i == bad_at);
  endtask

  function automatic string rand_str();
    string set, r;
    set = "ACGIPRTY ";
    r = "            ";
    for (int i = 0; i < ND; i++) r[i] = set[$urandom_range(0, 8)];
    return r;
  endfunction

  task automatic rd(int a, logic [6:0] exp, string tag);
    @(posedge clk); #1 rd_addr = 4'(a);
    @(posedge clk);
    @(negedge clk);
    chk(tag, rd_char, exp);
  endtask

  task automatic check_buf(string tag);
    for (int i = 0; i < ND; i++) rd(i, last_frame[i][6:0], $sformatf("%s[%0d]", tag, i));
  endtask

  int n_fv = 0, n_seq = 0, cyc = 0;
  int fv_cyc[$];
  bit last_gerr = 1'b0;

  task automatic settle(string tag);
    idle(6);
    chk({tag, "_pending"}, fq.size(), 0);
    chk({tag, "_seq_count"}, n_seq, exp_seq);
    chk({tag, "_frame_count"}, frame_count, exp_count & 255);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (seq_err) n_seq++;
    if (frame_valid) begin
      n_fv++;
      fv_cyc.push_back(cyc);
      last_gerr = frame_glyph_err;
      chk("frame_expected", fq.size() > 0, 1);
      if (fq.size() > 0) begin
        fe = fq.pop_front();
        chk("frame_changed", frame_changed, fe.changed);
        chk("frame_glyph_err", frame_glyph_err, fe.err);
      end
    end
  end

  int fv0, seq0;
  string s;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_outputs", {rd_char, frame_valid, frame_changed, frame_glyph_err, seq_err, frame_count}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    check_buf("after_reset");

    // back-to-back scanner stream, two identical frames
    send("PATY GARCIA ", 1, -1);
    send("PATY GARCIA ", 1, -1);
    settle("paty");
    chk("fv_pulses", fv_cyc.size(), 2);
    if (fv_cyc.size() >= 2) chk("frame_gap", fv_cyc[1] - fv_cyc[0], 12);
    chk("frame_count_2", frame_count, 2);
    rd(0, 7'h50, "rd0"); rd(3, 7'h59, "rd3"); rd(4, 7'h20, "rd4");
    rd(10, 7'h41, "rd10"); rd(11, 7'h20, "rd11");

    // held sel: one event per digit
    fv0 = n_fv;
    send("PATY GARCIA ", 3, -1);
    settle("hold");
    chk("hold_one_frame", n_fv - fv0, 1);
    check_buf("hold_buf");

    // out-of-order index
    seq0 = n_seq; fv0 = n_fv;
    drive(ND'(1), "C", 0); drive(ND'(2), "A", 0); drive(ND'(4), "T", 0); drive(ND'(32), "I", 0);
    idle(5);
    chk("skip_seq_err", n_seq - seq0, 1);
    chk("skip_no_frame", n_fv - fv0, 0);
    send(rand_str(), 1, -1);
    settle("after_skip");
    check_buf("after_skip_buf");

    // non-one-hot sel mid-frame
    seq0 = n_seq;
    s = rand_str();
    for (int i = 0; i < 6; i++) drive(ND'(1) << i, s[i], 0);
    drive(ND'(3), "A", 0);
    settle("nonhot");
    chk("nonhot_seq_err", n_seq - seq0, 1);
    check_buf("nonhot_buf");

    // unknown glyph at index 6
    send(rand_str(), 1, 6);
    settle("badglyph");
    rd(6, 7'h3F, "bad_glyph_rd");
    chk("glyph_err_flag", last_gerr, 1);

    // reset mid-frame
    s = rand_str();
    for (int i = 0; i < 8; i++) drive(ND'(1) << i, s[i], 0);
    @(posedge clk); #1 rst_n = 1'b0; sel = '0; segm = '0; model_reset();
    @(negedge clk);
    chk("midreset_outputs", {rd_char, frame_valid, frame_changed, frame_glyph_err, seq_err, frame_count}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    check_buf("midreset_buf");
    send(rand_str(), 1, -1);
    settle("post_reset");
    chk("post_reset_count", frame_count, 1);
    check_buf("post_reset_buf");

    // randomized stream with occasional faults
    for (int f = 0; f < 40; f++) begin
      int hold;
      s = rand_str();
      hold = $urandom_range(1, 3);
      for (int i = 0; i < ND; i++) begin
        int r;
        r = $urandom_range(0, 59);
        if (r == 0) drive(ND'(3) << $urandom_range(0, ND - 2), "A", 0);
        if (r == 1) continue;
        repeat (hold) drive(ND'(1) << i, s[i], $urandom_range(0, 29) == 0);
      end
      idle($urandom_range(0, 2));
    end
    settle("random");
    check_buf("random_buf");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
